// File: rtl/mem_wb_pkg.sv
// MEM->WB stage shared definitions.
// Default widths and the writeback entry layout.
package mem_wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DIR_W  = 32;
  localparam int DEF_CNT_W  = 16;

  typedef struct packed {
    logic                  we;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_DIR_W-1:0]  dir;
  } wb_entry_t;

endpackage

// File: rtl/mem_wb_slot.sv
// One valid+payload register of the MEM->WB stage.
// Clear wins over load so a flush drops a same-cycle load.
module mem_wb_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with valid/ready handshake,
// flush, optional skid slot and a back-pressure counter.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIR_W  = DEF_DIR_W,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DIR_W-1:0]  in_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [DATA_W-1:0] out_data,
  output logic [DIR_W-1:0]  out_dir,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int W = 1 + DATA_W + DIR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic         accept;
  logic         drain;
  logic [W-1:0] in_pack;
  logic         main_valid;
  logic         main_load;
  logic         main_clear;
  logic [W-1:0] main_d;
  logic [W-1:0] main_q;

  assign in_pack = {in_we, in_data, in_dir};
  assign accept  = in_valid & in_ready;
  assign drain   = main_valid & out_ready;

  // Main empties on drain unless refilled the same edge.
  assign main_clear = flush | (drain & ~main_load);

  generate
    if (SKID) begin : g_skid
      logic         skid_valid;
      logic [W-1:0] skid_q;
      logic         skid_load;
      logic         skid_clear;

      assign in_ready   = ~skid_valid;
      assign main_load  = skid_valid ? drain
                                     : accept & (~main_valid | drain);
      assign main_d     = skid_valid ? skid_q : in_pack;
      assign skid_load  = accept & main_valid & ~drain;
      assign skid_clear = flush | (skid_valid & drain);

      mem_wb_slot #(.W(W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_pack),
        .valid (skid_valid),
        .q     (skid_q)
      );
    end else begin : g_single
      assign in_ready  = ~main_valid | out_ready;
      assign main_load = accept;
      assign main_d    = in_pack;
    end
  endgenerate

  mem_wb_slot #(.W(W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  assign out_valid = main_valid;
  assign out_we    = main_valid & main_q[W-1];
  assign out_data  = main_q[DATA_W+DIR_W-1:DIR_W];
  assign out_dir   = main_q[DIR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid & ~out_ready & (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench: SKID=1, SKID=0 and CNT_W=4 instances
// driven by one shared stimulus stream.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_we;
  logic [31:0] in_data;
  logic [31:0] in_dir;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_we;
  logic [31:0] a_out_data, a_out_dir;
  logic [15:0] a_stall;
  logic        b_in_ready, b_out_valid, b_out_we;
  logic [31:0] b_out_data, b_out_dir;
  logic [15:0] b_stall;
  logic        c_in_ready, c_out_valid, c_out_we;
  logic [31:0] c_out_data, c_out_dir;
  logic [3:0]  c_stall;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.SKID(1'b1)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_we(in_we), .in_data(in_data), .in_dir(in_dir),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_we(a_out_we), .out_data(a_out_data),
    .out_dir(a_out_dir), .stall_cnt(a_stall)
  );

  mem_wb_stage #(.SKID(1'b0)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_we(in_we), .in_data(in_data), .in_dir(in_dir),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_we(b_out_we), .out_data(b_out_data),
    .out_dir(b_out_dir), .stall_cnt(b_stall)
  );

  mem_wb_stage #(.SKID(1'b1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready),
    .in_we(in_we), .in_data(in_data), .in_dir(in_dir),
    .out_valid(c_out_valid), .out_ready(out_ready),
    .out_we(c_out_we), .out_data(c_out_data),
    .out_dir(c_out_dir), .stall_cnt(c_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_we = 1'b0;
    in_data = '0; in_dir = '0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_a_in_ready", 32'(a_in_ready), 1);
    chk("rst_a_out_valid", 32'(a_out_valid), 0);
    chk("rst_a_out_we", 32'(a_out_we), 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_out_dir", a_out_dir, 0);
    chk("rst_a_stall", 32'(a_stall), 0);
    chk("rst_b_in_ready", 32'(b_in_ready), 1);

    // streaming, one per cycle, latency 1
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_we = 1'b1;
      in_data = 32'h10 + 32'(i); in_dir = 32'(i);
      tick();
      chk("str_a_valid", 32'(a_out_valid), 1);
      chk("str_a_data", a_out_data, 32'h10 + 32'(i));
      chk("str_a_dir", a_out_dir, 32'(i));
      chk("str_a_we", 32'(a_out_we), 1);
      chk("str_a_in_ready", 32'(a_in_ready), 1);
      chk("str_b_data", b_out_data, 32'h10 + 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("str_a_empty", 32'(a_out_valid), 0);
    chk("str_b_empty", 32'(b_out_valid), 0);
    chk("str_a_stall", 32'(a_stall), 0);

    // back-pressure
    in_valid = 1'b1; in_data = 32'h10; in_dir = 0; out_ready = 1'b0;
    tick();
    chk("bp_a_in_ready1", 32'(a_in_ready), 1);
    chk("bp_b_in_ready1", 32'(b_in_ready), 0);
    in_data = 32'h11; in_dir = 1;
    tick();
    in_data = 32'h12; in_dir = 2;
    repeat (4) tick();
    chk("bp_a_data", a_out_data, 32'h10);
    chk("bp_a_in_ready", 32'(a_in_ready), 0);
    chk("bp_a_stall", 32'(a_stall), 5);
    chk("bp_b_data", b_out_data, 32'h10);
    chk("bp_b_valid", 32'(b_out_valid), 1);
    chk("bp_b_stall", 32'(b_stall), 5);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_b_comb_ready", 32'(b_in_ready), 1);
    chk("bp_a_reg_ready", 32'(a_in_ready), 0);
    tick();
    chk("rel_a_data", a_out_data, 32'h11);
    chk("rel_a_dir", a_out_dir, 1);
    chk("rel_a_valid", 32'(a_out_valid), 1);
    chk("rel_a_in_ready", 32'(a_in_ready), 1);
    chk("rel_a_stall", 32'(a_stall), 5);
    chk("rel_b_valid", 32'(b_out_valid), 0);
    tick();
    chk("rel_a_empty", 32'(a_out_valid), 0);

    // flush with both slots full and an offered entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h30; in_dir = 32'h30;
    tick();
    in_data = 32'h31; in_dir = 32'h31;
    tick();
    chk("fl_a_full", 32'(a_in_ready), 0);
    chk("fl_a_valid", 32'(a_out_valid), 1);
    flush = 1'b1; in_data = 32'h32; in_dir = 32'h32; out_ready = 1'b1;
    #1;
    chk("fl_b_in_ready", 32'(b_in_ready), 1);
    tick();
    flush = 1'b0;
    chk("fl_a_valid0", 32'(a_out_valid), 0);
    chk("fl_a_we0", 32'(a_out_we), 0);
    chk("fl_a_in_ready", 32'(a_in_ready), 1);
    chk("fl_b_valid0", 32'(b_out_valid), 0);
    chk("fl_b_we0", 32'(b_out_we), 0);
    chk("fl_a_stall", 32'(a_stall), 6);
    in_data = 32'h20; in_dir = 32'h20; in_we = 1'b1;
    tick();
    chk("pf_a_valid", 32'(a_out_valid), 1);
    chk("pf_a_data", a_out_data, 32'h20);
    chk("pf_b_data", b_out_data, 32'h20);
    in_valid = 1'b0;
    tick();
    chk("pf_a_alone", 32'(a_out_valid), 0);

    // counter saturation
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h40; in_dir = 32'h40;
    repeat (20) tick();
    chk("sat_c_stall", 32'(c_stall), 15);
    chk("sat_a_stall", 32'(a_stall), 25);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_c_flush", 32'(c_stall), 15);
    chk("sat_c_valid0", 32'(c_out_valid), 0);
    chk("sat_a_flush", 32'(a_stall), 26);

    // reset mid-stream
    in_valid = 1'b1; in_data = 32'h50; in_dir = 5; out_ready = 1'b1;
    tick();
    chk("mr_a_valid", 32'(a_out_valid), 1);
    chk("mr_a_data", a_out_data, 32'h50);
    rst = 1'b1;
    tick();
    chk("mr_a_valid0", 32'(a_out_valid), 0);
    chk("mr_a_we0", 32'(a_out_we), 0);
    chk("mr_a_stall0", 32'(a_stall), 0);
    chk("mr_a_in_ready", 32'(a_in_ready), 1);
    chk("mr_a_data0", a_out_data, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mr_c_stall0", 32'(c_stall), 0);
    chk("mr_b_valid0", 32'(b_out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM→WB pipeline stage register for the filter processor datapath. It carries the writeback payload (write enable, data, destination) from the memory stage to the writeback stage with a valid/ready handshake, synchronous flush, and an optional skid slot that breaks the combinational ready path. It also counts back-pressure cycles for performance analysis. It replaces the free-running stage register between MEM and WB.

## Interface
Parameters:
- DATA_W, 32, writeback data width
- DIR_W, 32, writeback destination/address width
- SKID, 1, 1 = two-slot skid buffer with registered in_ready; 0 = single slot with combinational in_ready
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held entries
- in_valid  in  1  MEM-side entry present
- in_ready  out  1  stage can accept this cycle
- in_we  in  1  writeback enable of the entry
- in_data  in  DATA_W  writeback data
- in_dir  in  DIR_W  writeback destination
- out_valid  out  1  WB-side entry present
- out_ready  in  1  WB consumes this cycle
- out_we  out  1  writeback enable, forced 0 when out_valid=0
- out_data  out  DATA_W  held data
- out_dir  out  DIR_W  held destination
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

## Operation
- Accept = in_valid & in_ready; drain = out_valid & out_ready.
- Slots: main (drives outputs) and, when SKID=1, skid. Each slot holds {valid, we, data, dir}.
- SKID=0: in_ready = ~out_valid | out_ready. On accept, main loads the input. On drain without accept, main becomes invalid.
- SKID=1: in_ready = ~skid_valid, taken straight from a register.
  - Accept while main is empty or draining, skid empty: main loads the input.
  - Accept while main is valid and not draining: skid loads the input.
  - Drain while skid is valid: main loads the skid entry and skid clears. No accept is possible that cycle.
- Order is strictly FIFO. There is no reordering, duplication or loss except on flush.
- Flush: at the next edge both valid bits clear. An entry accepted in the flush cycle is discarded. in_ready still follows its formula during flush. Payload registers may keep stale values, but out_we is masked to 0.
- rst overrides flush and handshake. All valid bits, payloads and stall_cnt go to 0.
- stall_cnt increments when out_valid & ~out_ready. It saturates at 2^CNT_W−1 and is cleared only by rst, not by flush.

## Timing
- Reset values: in_ready=1, out_valid=0, out_we=0, out_data=0, out_dir=0, stall_cnt=0.
- Latency: an entry accepted at edge N is visible on the outputs after edge N (one cycle) when main is empty.
- Throughput: one entry per cycle while out_ready=1, in both modes.
- SKID=1, out_ready low: at most two entries are held, and in_ready falls the cycle after skid fills.
- SKID=1, out_ready released: in_ready rises the cycle after skid empties.
- Simultaneous accept and drain with main only valid: main is replaced by the new entry and stays valid (no bubble).
- Flush and rst take effect on the same edge they are sampled. out_valid=0 the following cycle.

## Structure
- Package mem_wb_pkg holds:
  - default width constants (DATA_W=32, DIR_W=32, CNT_W=16);
  - a packed struct wb_entry_t {we, data, dir} parametrised via localparams of the package defaults.
- One sub-module, mem_wb_slot. It is a single valid+payload register with load, clear and sync reset. It is instantiated once for main and once for skid under generate on SKID.

## Test plan
- Reset: assert rst 2 cycles mid-stream with out_valid=1 → next cycle out_valid=0, out_we=0, stall_cnt=0, in_ready=1.
- Streaming, SKID=1: 8 entries (data=0x10..0x17, dir=i, we=1) with out_ready=1 → all 8 appear in order, one per cycle, latency 1.
- Back-pressure, SKID=1: out_ready=0 for 5 cycles while in_valid=1 → entries 0x10 and 0x11 held, in_ready=0, stall_cnt=5. On release, 0x10 then 0x11 are output with no loss.
- SKID=0: same stimulus → only 0x10 held, and in_ready=out_ready combinationally in the same cycle.
- Flush with both slots full plus an accept in the same cycle → next cycle out_valid=0, out_we=0, and the first post-flush entry 0x20 appears alone.
- Saturation, CNT_W=4: out_ready=0 for 20 cycles → stall_cnt stops at 15, and a flush leaves it at 15.
